uart_reg_ctrl_v2: RTL

Parametrised successor register controller for the FPGA UART. It contains a CPU-facing register file (CTRL, STATUS, IRQ_EN, TX_DATA, RX_DATA) and drives the Tx/Rx module and FIFO handshakes. It also holds sticky error/overflow flags and generates a maskable interrupt. It sits between the CPU bus and the uart_tx/uart_rx/FIFO instances.

---
 rtl/uart_reg_ctrl_v2.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_ctrl_v2.sv
// CPU register file and Tx/Rx/FIFO handshake controller for the FPGA UART.
// Optional UART_REG_IRQ_EN adds the IRQ_EN mask register and irq_o.
module uart_reg_ctrl_v2 #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int STOP_CONF_W     = 2,
   parameter int DATA_CONF_W     = 2,
   parameter int BAUD_RATE_SEL_W = 2,
   parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
   parameter int BUS_ADDR_W      = 3,
   parameter int BUS_DATA_W      = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [BUS_ADDR_W-1:0]      bus_addr_i,
   input  logic                       bus_wr_en_i,
   input  logic                       bus_rd_en_i,
   input  logic [BUS_DATA_W-1:0]      bus_wdata_i,
   output logic [BUS_DATA_W-1:0]      bus_rdata_o,
   output logic                       bus_rvalid_o,
   input  logic                       tx_busy_i,
   input  logic                       tx_done_i,
   input  logic                       rx_busy_i,
   input  logic                       rx_done_i,
   input  logic                       rx_parity_err_i,
   input  logic                       rx_stop_err_i,
   input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
   input  logic [MAX_UART_DATA_W-1:0] rx_fifo_data_i,
   input  logic                       tx_fifo_full_i,
   input  logic                       tx_fifo_nearly_full_i,
   input  logic                       tx_fifo_empty_i,
   input  logic                       tx_fifo_nearly_empty_i,
   input  logic                       rx_fifo_full_i,
   input  logic                       rx_fifo_nearly_full_i,
   input  logic                       rx_fifo_empty_i,
   input  logic                       rx_fifo_nearly_empty_i,
   output logic                       tx_fifo_push_o,
   output logic                       tx_fifo_pop_o,
   output logic                       rx_fifo_push_o,
   output logic                       rx_fifo_pop_o,
   output logic [MAX_UART_DATA_W-1:0] tx_data_o,
   output logic [MAX_UART_DATA_W-1:0] rx_fifo_data_o,
   output logic                       tx_start_o,
   output logic [BAUD_RATE_SEL_W-1:0] baud_sel_o,
   output logic                       tx_en_o,
   output logic                       rx_en_o,
   output logic                       tx_fifo_en_o,
   output logic                       rx_fifo_en_o,
   output logic [TOTAL_CONF_W-1:0]    tx_conf_o,
   output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
   output logic                       irq_o
);

   localparam int CTRL_W     = 4 + TOTAL_CONF_W + BAUD_RATE_SEL_W;
   localparam int N_STICKY   = 5;
   localparam int STICKY_LSB = 10;
   localparam int STATUS_W   = STICKY_LSB + N_STICKY;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_WAIT
   } tx_state_e;

   logic [CTRL_W-1:0]          ctrl_q;
   logic [N_STICKY-1:0]        sticky_q;
   logic [N_STICKY-1:0]        sticky_set;
   logic [N_STICKY-1:0]        sticky_clr;
   logic [N_STICKY-1:0]        sticky_d;
   logic [STICKY_LSB-1:0]      status_live;
   logic [BUS_DATA_W-1:0]      rdata_d;
   logic [BUS_DATA_W-1:0]      rdata_q;
   logic                       rvalid_q;
   logic                       tx_push_q;
   logic [MAX_UART_DATA_W-1:0] tx_data_q;
   logic                       rx_pop_q;
   logic                       tx_start_q;
   logic                       tx_pop_q;
   tx_state_e                  tx_state_q;
   logic                       unused_wdata;

   logic wr_ctrl, wr_status, wr_tx;
   logic rd_ctrl, rd_status, rd_rx;
   logic rx_accept, tx_go;

   assign wr_ctrl   = bus_wr_en_i && (bus_addr_i == BUS_ADDR_W'(0));
   assign wr_status = bus_wr_en_i && (bus_addr_i == BUS_ADDR_W'(1));
   assign wr_tx     = bus_wr_en_i && (bus_addr_i == BUS_ADDR_W'(3));
   assign rd_ctrl   = bus_rd_en_i && (bus_addr_i == BUS_ADDR_W'(0));
   assign rd_status = bus_rd_en_i && (bus_addr_i == BUS_ADDR_W'(1));
   assign rd_rx     = bus_rd_en_i && (bus_addr_i == BUS_ADDR_W'(4));

   assign unused_wdata = ^bus_wdata_i;

   assign tx_en_o      = ctrl_q[0];
   assign rx_en_o      = ctrl_q[1];
   assign tx_fifo_en_o = ctrl_q[2];
   assign rx_fifo_en_o = ctrl_q[3];
   assign tx_conf_o    = ctrl_q[4 +: TOTAL_CONF_W];
   assign rx_conf_o    = ctrl_q[4 +: TOTAL_CONF_W];
   assign baud_sel_o   = ctrl_q[4+TOTAL_CONF_W +: BAUD_RATE_SEL_W];

   // Received characters go straight into the Rx FIFO in the done cycle
   assign rx_accept      = rx_done_i & ctrl_q[1] & ctrl_q[3];
   assign rx_fifo_push_o = rx_accept & ~rx_fifo_full_i;
   assign rx_fifo_data_o = rx_data_i;

   assign tx_go = ctrl_q[0] & ctrl_q[2] & ~tx_fifo_empty_i & ~tx_busy_i;

   assign status_live = {
      rx_fifo_full_i, rx_fifo_nearly_full_i,
      rx_fifo_empty_i, rx_fifo_nearly_empty_i,
      tx_fifo_full_i, tx_fifo_nearly_full_i,
      tx_fifo_empty_i, tx_fifo_nearly_empty_i,
      rx_busy_i, tx_busy_i
   };

   assign sticky_set = {
      rd_rx & rx_fifo_empty_i,
      wr_tx & tx_fifo_full_i,
      rx_accept & rx_fifo_full_i,
      rx_done_i & rx_stop_err_i,
      rx_done_i & rx_parity_err_i
   };

   assign sticky_clr = wr_status ?
      bus_wdata_i[STICKY_LSB +: N_STICKY] : '0;

   // Set beats clear when both hit the same bit in one cycle
   assign sticky_d = (sticky_q & ~sticky_clr) | sticky_set;

`ifdef UART_REG_IRQ_EN
   logic [N_STICKY-1:0] irq_en_q;
   logic                irq_q;
   logic                wr_irq_en;
   logic                rd_irq_en;

   assign wr_irq_en = bus_wr_en_i && (bus_addr_i == BUS_ADDR_W'(2));
   assign rd_irq_en = bus_rd_en_i && (bus_addr_i == BUS_ADDR_W'(2));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_irq_en)
            irq_en_q <= bus_wdata_i[STICKY_LSB +: N_STICKY];
         irq_q <= |(sticky_d & irq_en_q);
      end
   end

   assign irq_o = irq_q;
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      rdata_d = '0;
      unique case (1'b1)
         rd_ctrl:   rdata_d = BUS_DATA_W'(ctrl_q);
         rd_status: rdata_d = BUS_DATA_W'({sticky_q, status_live});
`ifdef UART_REG_IRQ_EN
         rd_irq_en: rdata_d = BUS_DATA_W'({irq_en_q, {STICKY_LSB{1'b0}}});
`endif
         rd_rx: begin
            if (!rx_fifo_empty_i)
               rdata_d = BUS_DATA_W'(rx_fifo_data_i);
         end
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q    <= '0;
         sticky_q  <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         rx_pop_q  <= 1'b0;
         tx_push_q <= 1'b0;
         tx_data_q <= '0;
      end else begin
         if (wr_ctrl)
            ctrl_q <= bus_wdata_i[CTRL_W-1:0];
         sticky_q  <= sticky_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= bus_rd_en_i;
         rx_pop_q  <= rd_rx & ~rx_fifo_empty_i;
         tx_push_q <= wr_tx & ~tx_fifo_full_i;
         if (wr_tx && !tx_fifo_full_i)
            tx_data_q <= bus_wdata_i[MAX_UART_DATA_W-1:0];
      end
   end

   // Tx FSM: one START cycle, then hold until uart_tx reports done
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_q <= TX_IDLE;
         tx_start_q <= 1'b0;
         tx_pop_q   <= 1'b0;
      end else begin
         unique case (tx_state_q)
            TX_IDLE: begin
               if (tx_go) begin
                  tx_state_q <= TX_START;
                  tx_start_q <= 1'b1;
                  tx_pop_q   <= 1'b1;
               end
            end
            TX_START: begin
               tx_state_q <= TX_WAIT;
               tx_start_q <= 1'b0;
               tx_pop_q   <= 1'b0;
            end
            TX_WAIT: begin
               if (tx_done_i)
                  tx_state_q <= TX_IDLE;
            end
            default: begin
               tx_state_q <= TX_IDLE;
               tx_start_q <= 1'b0;
               tx_pop_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus_rdata_o    = rdata_q;
   assign bus_rvalid_o   = rvalid_q;
   assign rx_fifo_pop_o  = rx_pop_q;
   assign tx_fifo_push_o = tx_push_q;
   assign tx_data_o      = tx_data_q;
   assign tx_start_o     = tx_start_q;
   assign tx_fifo_pop_o  = tx_pop_q;

   logic [STATUS_W-1:0] unused_status_w;
   assign unused_status_w = '0;

endmodule
